// File: rtl/mem_dump_if.sv
// mem_dump_if: memory read port and byte stream channel of the readback engine.
// The engine (master) drives the memory address/strobe and the stream
// data/valid/last; the memory plus downstream sink (slave) return read data
// and out_ready.
interface mem_dump_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output mem_addr,
    output mem_rd,
    input  mem_rdata,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  mem_addr,
    input  mem_rd,
    output mem_rdata,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/mem_dump.sv
// mem_dump: reads a contiguous (possibly wrapping) address range out of the
// unified memory one byte at a time and streams each byte on a valid/ready
// channel, keeping a running mod-2^DATA_W checksum of accepted bytes.
// Every output is a flop; its next value is decoded from the next state, so
// out_ready never reaches out_valid combinationally.
module mem_dump #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  mem_dump_if.master        bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              olast_q, olast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              handshake;
  logic              at_last;

  assign handshake = valid_q & bus.out_ready;
  assign at_last   = (cur_q == last_q);

  // Next-state and next-output decode; outputs are derived from the next
  // state so they appear registered in the same cycle the state is entered.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    data_d  = data_q;
    sum_d   = sum_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          last_d  = end_addr;
          sum_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        data_d  = bus.mem_rdata;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          sum_d = sum_q + data_q;
          if (at_last) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + ADDR_ONE;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_d    = (state_d == ST_READ);
    valid_d = (state_d == ST_SEND);
    olast_d = (state_d == ST_SEND) && (cur_d == last_d);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and output registers; an asynchronous reset abandons any transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      olast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      olast_q <= olast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_addr  = cur_q;
  assign bus.mem_rd    = rd_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = olast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum      = sum_q;

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed bench for mem_dump with a 256x8 memory model whose
// read data appears the cycle after mem_rd.
module tb_mem_dump;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [7:0] end_addr;
  logic       busy;
  logic       done;
  logic [7:0] checksum;

  mem_dump_if #(.ADDR_W(8), .DATA_W(8)) bus_if ();

  mem_dump #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .bus        (bus_if),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic [7:0] got_data [$];
  logic       got_last [$];
  logic [7:0] rd_addrs [$];
  int         first_rd;
  int         done_at;
  int         done_cnt;
  int         stall_err;
  int         stall_cycles;
  bit         timed_out;
  logic       busy_after_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous read, data valid the cycle after mem_rd.
  always @(posedge clk or posedge rst) begin
    if (rst) bus_if.mem_rdata <= 8'h00;
    else if (bus_if.mem_rd) bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  // Runs one dump, recording streamed bytes, read addresses and done timing.
  // ready_mode 0 holds out_ready high, 1 toggles it 0/1 every 2 cycles.
  task automatic run_dump(input logic [7:0] sa, input logic [7:0] ea,
                          input int ready_mode, input bit inject_start);
    logic       prev_valid, prev_ready, prev_last, rdy;
    logic [7:0] prev_data;
    bit         injected, finished;
    got_data.delete();
    got_last.delete();
    rd_addrs.delete();
    first_rd = -1; done_at = -1; done_cnt = 0;
    stall_err = 0; stall_cycles = 0; timed_out = 0; busy_after_done = 1'bx;
    prev_valid = 0; prev_ready = 0; prev_last = 0; prev_data = 0;
    injected = 0; finished = 0;
    @(negedge clk);
    start_addr = sa; end_addr = ea; start = 1'b1;
    bus_if.out_ready = (ready_mode == 0);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (bus_if.mem_rd) begin
        rd_addrs.push_back(bus_if.mem_addr);
        if (first_rd < 0) first_rd = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (prev_valid && !prev_ready && bus_if.out_valid) begin
        stall_cycles++;
        if (bus_if.out_data !== prev_data || bus_if.out_last !== prev_last) stall_err++;
      end
      if (inject_start) begin
        if (start) start = 1'b0;
        else if (!injected && bus_if.out_valid) begin
          start = 1'b1; start_addr = 8'h00; end_addr = 8'h00; injected = 1;
        end
      end
      rdy = (ready_mode == 0) ? 1'b1 : (((cyc / 2) % 2) == 1);
      bus_if.out_ready = rdy;
      if (bus_if.out_valid && rdy) begin
        got_data.push_back(bus_if.out_data);
        got_last.push_back(bus_if.out_last);
      end
      prev_valid = bus_if.out_valid;
      prev_ready = rdy;
      prev_data  = bus_if.out_data;
      prev_last  = bus_if.out_last;
      if (done_at >= 0 && cyc == done_at + 1) begin
        busy_after_done = busy;
        finished = 1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!finished) timed_out = 1;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_rd} !== 9'h000) begin
      errors++;
      $display("[TB] FAIL reset_mem: got addr=%0d rd=%0b expected 0/0", bus_if.mem_addr, bus_if.mem_rd);
    end
    checks++;
    if ({bus_if.out_data, bus_if.out_valid, bus_if.out_last} !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_out: got data=%0h valid=%0b last=%0b expected 0", bus_if.out_data, bus_if.out_valid, bus_if.out_last);
    end
    checks++;
    if ({busy, done, checksum} !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_status: got busy=%0b done=%0b sum=%0h expected 0", busy, done, checksum);
    end
  endtask

  task automatic test_range_dump();
    logic [7:0] exp_d [4];
    exp_d = '{8'd6, 8'd1, 8'd2, 8'd0};
    run_dump(8'd128, 8'd131, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("[TB] FAIL range_count: got %0d bytes (timeout=%0b) expected 4", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
          errors++;
          $display("[TB] FAIL range_byte%0d: got %0h last=%0b expected %0h last=%0b", i, got_data[i], got_last[i], exp_d[i], (i == 3));
        end
      end
    end
    checks++;
    if (checksum !== 8'd9) begin
      errors++;
      $display("[TB] FAIL range_checksum: got %0h expected 9", checksum);
    end
    checks++;
    if (done_at - first_rd != 12 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL range_done_timing: got %0d cycles, %0d pulses expected 12, 1", done_at - first_rd, done_cnt);
    end
    checks++;
    if (busy_after_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_busy_fall: got %0b expected 0", busy_after_done);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    exp_d = '{8'd6, 8'd1, 8'd2, 8'd0};
    run_dump(8'd128, 8'd131, 1, 0);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d bytes (timeout=%0b) expected 4", got_data.size(), timed_out);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i]) begin
          errors++;
          $display("[TB] FAIL bp_byte%0d: got %0h expected %0h", i, got_data[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (stall_cycles == 0 || stall_err != 0) begin
      errors++;
      $display("[TB] FAIL bp_stable: got %0d unstable of %0d stalled cycles expected 0 of >0", stall_err, stall_cycles);
    end
    checks++;
    if (checksum !== 8'd9 || done_cnt != 1) begin
      errors++;
      $display("[TB] FAIL bp_checksum: got %0h, %0d done expected 9, 1", checksum, done_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d [4];
    logic [7:0] exp_a [4];
    exp_d = '{8'h80, 8'h90, 8'h00, 8'h10};
    exp_a = '{8'd254, 8'd255, 8'd0, 8'd1};
    run_dump(8'd254, 8'd1, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 4 || rd_addrs.size() != 4) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d bytes %0d reads expected 4, 4", got_data.size(), rd_addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i] || rd_addrs[i] !== exp_a[i]) begin
          errors++;
          $display("[TB] FAIL wrap_%0d: got data=%0h addr=%0d expected %0h, %0d", i, got_data[i], rd_addrs[i], exp_d[i], exp_a[i]);
        end
      end
    end
    checks++;
    if (checksum !== 8'h20) begin
      errors++;
      $display("[TB] FAIL wrap_checksum: got %0h expected 20", checksum);
    end
  endtask

  task automatic test_single_byte();
    run_dump(8'd139, 8'd139, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d bytes expected 1", got_data.size());
    end else begin
      checks++;
      if (got_data[0] !== 8'hF0 || got_last[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL single_byte: got %0h last=%0b expected f0 last=1", got_data[0], got_last[0]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at - first_rd != 3) begin
      errors++;
      $display("[TB] FAIL single_done: got %0d pulses at %0d expected 1 at 3", done_cnt, done_at - first_rd);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (checksum !== 8'hF0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_checksum_hold: got %0h busy=%0b expected f0 busy=0", checksum, busy);
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] exp_d [4];
    exp_d = '{8'd6, 8'd1, 8'd2, 8'd0};
    run_dump(8'd128, 8'd131, 0, 1);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("[TB] FAIL swb_count: got %0d bytes expected 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_data[i] !== exp_d[i]) begin
          errors++;
          $display("[TB] FAIL swb_byte%0d: got %0h expected %0h", i, got_data[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (checksum !== 8'd9 || done_at - first_rd != 12 || rd_addrs.size() != 4) begin
      errors++;
      $display("[TB] FAIL swb_result: got sum=%0h cycles=%0d reads=%0d expected 9, 12, 4", checksum, done_at - first_rd, rd_addrs.size());
    end
  endtask

  task automatic test_reset_mid_op();
    int  sends;
    bit  found;
    int  dones;
    sends = 0; found = 0; dones = 0;
    @(negedge clk);
    start_addr = 8'd128; end_addr = 8'd131; start = 1'b1; bus_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (bus_if.out_valid) sends++;
      if (sends == 2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || checksum !== 8'd6) begin
      errors++;
      $display("[TB] FAIL rst_mid_reach: got found=%0b sum=%0h expected 1, 6", found, checksum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.mem_addr, bus_if.mem_rd, bus_if.out_data, bus_if.out_valid, bus_if.out_last,
         busy, done, checksum} !== 30'h0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got addr=%0d rd=%0b data=%0h v=%0b l=%0b busy=%0b done=%0b sum=%0h expected all 0",
               bus_if.mem_addr, bus_if.mem_rd, bus_if.out_data, bus_if.out_valid, bus_if.out_last, busy, done, checksum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_no_done: got %0d done/busy cycles expected 0", dones);
    end
    run_dump(8'd129, 8'd130, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 2 || got_data[0] !== 8'd1 || got_data[1] !== 8'd2 || checksum !== 8'd3) begin
      errors++;
      $display("[TB] FAIL rst_mid_redump: got %0d bytes sum=%0h expected 2 bytes (1,2) sum=3", got_data.size(), checksum);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    start_addr = 8'h00;
    end_addr = 8'h00;
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
    mem[254] = 8'h80; mem[255] = 8'h90; mem[0] = 8'h00; mem[1] = 8'h10;
    mem[139] = 8'hF0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_range_dump();
    test_backpressure();
    test_wrap();
    test_single_byte();
    test_start_while_busy();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
# mem_dump

Memory readback engine for the RISC_SPM platform. After a run, or whenever the CPU is idle, it reads a contiguous address range out of the 256×8 unified memory and streams the bytes on a valid/ready output channel. It also produces a running 8-bit checksum. Benches and debug hosts use it to read results back in hardware instead of preloading and peeking memory hierarchically.

## Interface
- ADDR_W, 8, memory address width (memory depth 2^ADDR_W)
- DATA_W, 8, memory word and output byte width
- clk  in  1  system clock, rising-edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- start_addr  in  ADDR_W  first address, latched on accepted start
- end_addr  in  ADDR_W  last address (inclusive), latched on accepted start
- mem_addr  out  ADDR_W  memory read address
- mem_rd  out  1  memory read strobe
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd
- out_data  out  DATA_W  streamed byte
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_last  out  1  high with out_valid on the final byte of the range
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse after the last byte is accepted
- checksum  out  DATA_W  mod-2^DATA_W sum of accepted bytes of the current or last dump

## Operation
- States: IDLE, READ, CAPT, SEND, DONE.
- IDLE: busy=0, mem_rd=0, out_valid=0. If start=1: latch cur←start_addr and last←end_addr, clear checksum to 0, go to READ.
- READ, one cycle: mem_rd=1, mem_addr=cur. Go to CAPT.
- CAPT, one cycle: mem_rd=0. Register mem_rdata into out_data. Go to SEND.
- SEND: out_valid=1 and out_last=(cur==last).
  - out_data, out_last and cur are held stable while out_ready=0.
  - On handshake (out_valid & out_ready): checksum←checksum+out_data (truncate to DATA_W).
  - Then, if cur==last, go to DONE. Otherwise cur←cur+1 (wraps 2^ADDR_W−1→0) and go to READ.
- DONE, one cycle: done=1, busy=1. Go to IDLE.
- Range length is ((end_addr−start_addr) mod 2^ADDR_W)+1.
  - end_addr<start_addr wraps through address 0.
  - start_addr==end_addr dumps exactly one byte.
- start is ignored in every state other than IDLE. Latched addresses cannot change mid-dump.
- mem_addr holds cur in all states. mem_rd=1 only in READ.
- checksum holds its value in IDLE until the next accepted start.
- Reset, including mid-dump: state→IDLE immediately. The transfer is abandoned and no done pulse is produced.

## Timing
- Reset values:
  - mem_addr=0, mem_rd=0
  - out_data=0, out_valid=0, out_last=0
  - busy=0, done=0, checksum=0
  - internal cur=0, last=0
- start sampled high at edge E0: busy and mem_rd go high after E0.
- mem_rdata is captured at E2. out_valid goes high after E2.
- Per-byte minimum is 3 cycles (READ, CAPT, SEND with out_ready=1). An N-byte dump with ready held high takes 3N cycles to the last handshake, plus 1 cycle for DONE.
- done is high in the cycle after the final handshake. busy falls one cycle later, and a new start is accepted from that cycle.
- All outputs are registered or decoded from state only. There is no combinational path from out_ready to out_valid.

## Test plan
- Range dump: preload mem[128..131]=6,1,2,0. Set start_addr=128, end_addr=131, out_ready=1.
  - Required: bytes 6,1,2,0 in order, out_last only on the 4th byte, checksum=9.
  - Required: done pulse 12 cycles after the first mem_rd.
- Backpressure: same range, out_ready toggled 0/1 every 2 cycles.
  - Required: the same byte sequence with no drop or duplicate; out_data stable while stalled; checksum=9.
- Wrap: mem[254]=0x80, mem[255]=0x90, mem[0]=0x00, mem[1]=0x10. Set start_addr=254, end_addr=1.
  - Required: 4 bytes in order 0x80,0x90,0x00,0x10; mem_addr sequence 254,255,0,1; checksum=0x20 (mod-256 overflow).
- Single byte: mem[139]=0xF0, start_addr=end_addr=139.
  - Required: one byte 0xF0 with out_last=1, checksum=0xF0, one done pulse.
- Start while busy: pulse start with start_addr=0 during the SEND of a 128..131 dump.
  - Required: no effect; the dump completes as in the range-dump scenario.
- Reset mid-op: assert rst during the second SEND of a 128..131 dump.
  - Required: all outputs 0 asynchronously and no done pulse.
  - Required: a new start afterwards dumps correctly from the fresh addresses with checksum restarted at 0.
